// File: rtl/prpg_hd_monitor_if.sv
// ---------------------------------------------------------------------------
// prpg_hd_monitor_if
// Groups the control, pattern-stream, HD-result-stream and statistics signals
// of prpg_hd_monitor. Clock and reset remain plain ports on the module.
//
//   start / run_len          : run control (driven by master)
//   pat_valid/pat_data       : upstream pattern stream (driven by master)
//   pat_ready                : pattern accept (driven by slave)
//   hd_valid/hd_data         : Hamming-distance FIFO head (driven by slave)
//   hd_ready                 : downstream pop (driven by master)
//   hd_sum/hd_cnt/avg_hd     : run statistics (driven by slave)
//   busy/done                : run status (driven by slave)
//
// master = the environment around the monitor, slave = the monitor itself.
// ---------------------------------------------------------------------------
interface prpg_hd_monitor_if;
    logic        start;
    logic [7:0]  run_len;
    logic        pat_valid;
    logic [7:0]  pat_data;
    logic        pat_ready;
    logic        hd_valid;
    logic [3:0]  hd_data;
    logic        hd_ready;
    logic [10:0] hd_sum;
    logic [7:0]  hd_cnt;
    logic [3:0]  avg_hd;
    logic        busy;
    logic        done;

    modport master (
        output start, run_len, pat_valid, pat_data, hd_ready,
        input  pat_ready, hd_valid, hd_data, hd_sum, hd_cnt, avg_hd, busy, done
    );

    modport slave (
        input  start, run_len, pat_valid, pat_data, hd_ready,
        output pat_ready, hd_valid, hd_data, hd_sum, hd_cnt, avg_hd, busy, done
    );
endinterface

// File: rtl/prpg_hd_monitor.sv
// ---------------------------------------------------------------------------
// prpg_hd_monitor
// Measures the Hamming distance between consecutive patterns of an upstream
// LFSR/CA generator over a run of run_len patterns. Each distance is queued in
// a small first-word-fall-through FIFO and accumulated into hd_sum/hd_cnt.
// At the end of the run the average distance is optionally computed with an
// 11-cycle restoring divider.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : prpg_hd_monitor_if.slave (start/run_len, pattern stream,
//            HD result stream, statistics, busy/done)
//
// Parameter:
//   FIFO_DEPTH : HD result FIFO entries, power of two, >= 2
//
// Build option:
//   PRPG_HD_MONITOR_AVG_EN defined   -> divider present, avg_hd valid in DONE
//   PRPG_HD_MONITOR_AVG_EN undefined -> no divider, DIV lasts one cycle,
//                                       avg_hd tied to 0
// ---------------------------------------------------------------------------
module prpg_hd_monitor #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    prpg_hd_monitor_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, FIRST, RUN, DIV, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  prev_reg, prev_next;
    logic [7:0]  consumed_reg, consumed_next;
    logic [7:0]  run_len_reg, run_len_next;
    logic [10:0] sum_reg, sum_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic [7:0]  consumed_inc;

    logic [3:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [OCC_W-1:0] occ_reg, occ_next;

    logic       start_acc;
    logic       accept;
    logic       push;
    logic       pop;
    logic       fifo_empty;
    logic       fifo_full;
    logic       div_last;
    logic [7:0] diff;
    logic [3:0] diff_bits [8];
    logic [3:0] hd_new;

    // ---------------------------------------------------------------------
    // Popcount of prev XOR current pattern
    // ---------------------------------------------------------------------
    assign diff = prev_reg ^ bus.pat_data;

    for (genvar gi = 0; gi < 8; gi++) begin : g_pop
        assign diff_bits[gi] = {3'b000, diff[gi]};
    end

    always_comb begin
        hd_new = 4'd0;
        for (int i = 0; i < 8; i++) begin
            hd_new = hd_new + diff_bits[i];
        end
    end

    // ---------------------------------------------------------------------
    // Handshakes and FIFO status
    // pat_ready looks only at the registered occupancy, so a pop in the same
    // cycle never opens the door for a push into a full FIFO.
    // ---------------------------------------------------------------------
    assign fifo_empty    = (occ_reg == '0);
    assign fifo_full     = (occ_reg == OCC_FULL);
    assign bus.pat_ready = (state_reg == FIRST) || ((state_reg == RUN) && !fifo_full);
    assign accept        = bus.pat_valid && bus.pat_ready;
    assign pop           = !fifo_empty && bus.hd_ready;
    assign start_acc     = bus.start && ((state_reg == IDLE) || (state_reg == DONE));

    // Head is gated so hd_data reads 0 whenever the FIFO is empty (incl. reset).
    assign bus.hd_valid  = !fifo_empty;
    assign bus.hd_data   = fifo_empty ? 4'd0 : fifo_mem[rd_ptr_reg];

    assign bus.hd_sum    = sum_reg;
    assign bus.hd_cnt    = cnt_reg;
    assign bus.busy      = (state_reg == FIRST) || (state_reg == RUN) || (state_reg == DIV);
    assign bus.done      = (state_reg == DONE);

    always_comb begin
        occ_next = occ_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + OCC_W'(1);
            2'b01:   occ_next = occ_reg - OCC_W'(1);
            default: occ_next = occ_reg;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM next state and run datapath
    // ---------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        prev_next     = prev_reg;
        consumed_next = consumed_reg;
        run_len_next  = run_len_reg;
        sum_next      = sum_reg;
        cnt_next      = cnt_reg;
        push          = 1'b0;
        consumed_inc  = consumed_reg + 8'd1;

        case (state_reg)
            IDLE, DONE: begin
                if (start_acc) begin
                    sum_next      = 11'd0;
                    cnt_next      = 8'd0;
                    consumed_next = 8'd0;
                    run_len_next  = bus.run_len;
                    state_next    = (bus.run_len == 8'd0) ? DIV : FIRST;
                end
            end
            FIRST: begin
                // First pattern only seeds the reference; no distance yet.
                if (accept) begin
                    prev_next     = bus.pat_data;
                    consumed_next = 8'd1;
                    state_next    = (run_len_reg == 8'd1) ? DIV : RUN;
                end
            end
            RUN: begin
                if (accept) begin
                    push          = 1'b1;
                    sum_next      = sum_reg + {7'd0, hd_new};
                    cnt_next      = cnt_reg + 8'd1;
                    prev_next     = bus.pat_data;
                    consumed_next = consumed_inc;
                    if (consumed_inc == run_len_reg) begin
                        state_next = DIV;
                    end
                end
            end
            DIV: begin
                state_next = div_last ? DONE : DIV;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            prev_reg     <= 8'd0;
            consumed_reg <= 8'd0;
            run_len_reg  <= 8'd0;
            sum_reg      <= 11'd0;
            cnt_reg      <= 8'd0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            occ_reg      <= '0;
        end else begin
            state_reg    <= state_next;
            prev_reg     <= prev_next;
            consumed_reg <= consumed_next;
            run_len_reg  <= run_len_next;
            sum_reg      <= sum_next;
            cnt_reg      <= cnt_next;
            occ_reg      <= occ_next;
            // Power-of-two depth: pointers wrap naturally.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= hd_new;
        end
    end

`ifdef PRPG_HD_MONITOR_AVG_EN
    // ---------------------------------------------------------------------
    // Restoring divider: hd_sum / hd_cnt, one quotient bit per DIV cycle,
    // 11 cycles for the 11-bit dividend. Operands are loaded on the edge that
    // enters DIV, using the sum that is being written on that same edge.
    // The true quotient never exceeds 8, so the low 4 bits are the result.
    // ---------------------------------------------------------------------
    logic [10:0] div_q_reg, div_q_next;
    logic [7:0]  div_r_reg, div_r_next;
    logic [3:0]  div_step_reg, div_step_next;
    logic [3:0]  avg_reg, avg_next;
    logic [8:0]  rem_shift;
    logic        div_load;

    assign div_load   = (state_next == DIV) && (state_reg != DIV);
    assign div_last   = (div_step_reg == 4'd10);
    assign bus.avg_hd = avg_reg;

    always_comb begin
        div_q_next    = div_q_reg;
        div_r_next    = div_r_reg;
        div_step_next = div_step_reg;
        avg_next      = avg_reg;
        rem_shift     = {div_r_reg, div_q_reg[10]};

        if (start_acc) begin
            avg_next = 4'd0;
        end

        if (div_load) begin
            div_q_next    = sum_next;
            div_r_next    = 8'd0;
            div_step_next = 4'd0;
        end else if (state_reg == DIV) begin
            if (rem_shift >= {1'b0, cnt_reg}) begin
                div_r_next = 8'(rem_shift - {1'b0, cnt_reg});
                div_q_next = {div_q_reg[9:0], 1'b1};
            end else begin
                div_r_next = rem_shift[7:0];
                div_q_next = {div_q_reg[9:0], 1'b0};
            end
            div_step_next = div_step_reg + 4'd1;
            if (div_last) begin
                // Divide-by-zero (no distances in the run) reports 0.
                avg_next = (cnt_reg == 8'd0) ? 4'd0 : div_q_next[3:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q_reg    <= 11'd0;
            div_r_reg    <= 8'd0;
            div_step_reg <= 4'd0;
            avg_reg      <= 4'd0;
        end else begin
            div_q_reg    <= div_q_next;
            div_r_reg    <= div_r_next;
            div_step_reg <= div_step_next;
            avg_reg      <= avg_next;
        end
    end
`else
    // No divider: DIV is a single pass-through cycle and no average exists.
    assign div_last   = 1'b1;
    assign bus.avg_hd = 4'd0;
`endif

endmodule
